// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes and
// the priority encoder that picks between them.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_RET  = 2'd1,
        SEL_TGT  = 2'd2,
        SEL_INC  = 2'd3
    } sel_t;

    // A return with an empty stack falls through to the sequential address.
    function automatic sel_t next_sel(
        input logic stall,
        input logic ret,
        input logic ras_empty,
        input logic redirect
    );
        if (stall)
            return SEL_HOLD;
        if (ret)
            return ras_empty ? SEL_INC : SEL_RET;
        if (redirect)
            return SEL_TGT;
        return SEL_INC;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push past full overwrites the oldest entry,
// and the pop data is always the entry just below the write pointer.
module ras_stack #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   push_data,
    output logic [W-1:0]                   pop_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rd_ptr;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign rd_ptr   = wp - PTR_W'(1);
    assign pop_data = mem[rd_ptr];

    // Entries are deliberately left out of reset; count=0 keeps them unreachable.
    always_ff @(posedge clock) begin
        if (push)
            mem[wp] <= push_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            count <= '0;
        end else if (push) begin
            wp <= wp + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            wp    <= rd_ptr;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, branch/jump/call/return
// redirects with a fixed priority, and sticky return-stack error flags.
module pc_unit #(
    parameter int ADDR_W     = 6,
    parameter int STEP       = 1,
    parameter int RESET_ADDR = 0,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               stall,
    input  logic                               branch_taken,
    input  logic                               jump,
    input  logic                               call,
    input  logic                               ret,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               err_clear,
    output logic [ADDR_W-1:0]                  pc,
    output logic [ADDR_W-1:0]                  pc_next,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic                               ras_overflow,
    output logic                               ras_underflow
);
    import pc_unit_pkg::*;

    sel_t              sel;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;
    logic              do_push;
    logic              do_pop;
    logic              set_overflow;
    logic              set_underflow;

    assign pc_inc = pc + ADDR_W'(STEP);

    // ret outranks call, so a simultaneous call is dropped without a push.
    assign do_push       = !stall && call && !ret;
    assign do_pop        = !stall && ret && !ras_empty;
    assign set_overflow  = do_push && ras_full;
    assign set_underflow = !stall && ret && ras_empty;

    always_comb begin
        sel     = next_sel(stall, ret, ras_empty, call || jump || branch_taken);
        pc_next = pc_inc;
        case (sel)
            SEL_HOLD: pc_next = pc;
            SEL_RET:  pc_next = ras_top;
            SEL_TGT:  pc_next = target;
            SEL_INC:  pc_next = pc_inc;
            default:  pc_next = pc_inc;
        endcase
    end

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc_inc),
        .pop_data  (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pc <= ADDR_W'(RESET_ADDR);
        else
            pc <= pc_next;
    end

    // Setting beats clearing; err_clear is honoured even while stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (set_overflow)
                ras_overflow <= 1'b1;
            else if (err_clear)
                ras_overflow <= 1'b0;
            if (set_underflow)
                ras_underflow <= 1'b1;
            else if (err_clear)
                ras_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed and random checks of pc_unit against a queue-based model of the
// fetch address and return-address stack.
module tb_pc_unit;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       stall, branch_taken, jump, call, ret, err_clear;
    logic [5:0] target;
    logic [5:0] pc, pc_next;
    logic [2:0] ras_count;
    logic       ras_overflow, ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [5:0] m_pc;
    logic [5:0] ras_q[$];
    logic       m_ovf, m_unf;

    always #5 clock = ~clock;

    pc_unit #(.ADDR_W(6), .STEP(1), .RESET_ADDR(0), .RAS_DEPTH(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .target        (target),
        .err_clear     (err_clear),
        .pc            (pc),
        .pc_next       (pc_next),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pc = 6'd0;
        ras_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic logic [5:0] model_next(input logic st, br, jp, cl, rt, input logic [5:0] tg);
        if (st) return m_pc;
        if (rt) return (ras_q.size() > 0) ? ras_q[$] : m_pc + 6'd1;
        if (cl || jp || br) return tg;
        return m_pc + 6'd1;
    endfunction

    task automatic model_step(input logic st, br, jp, cl, rt, input logic [5:0] tg, input logic clr);
        logic set_o, set_u;
        logic [5:0] nxt, ret_addr;
        set_o = 1'b0;
        set_u = 1'b0;
        nxt   = model_next(st, br, jp, cl, rt, tg);
        if (!st) begin
            if (rt) begin
                if (ras_q.size() > 0) void'(ras_q.pop_back());
                else set_u = 1'b1;
            end else if (cl) begin
                ret_addr = m_pc + 6'd1;
                ras_q.push_back(ret_addr);
                if (ras_q.size() > 4) begin
                    void'(ras_q.pop_front());
                    set_o = 1'b1;
                end
            end
        end
        m_pc  = nxt;
        m_ovf = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = set_u ? 1'b1 : (clr ? 1'b0 : m_unf);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".count"}, ras_count, ras_q.size());
        chk({tag, ".ovf"}, ras_overflow, m_ovf);
        chk({tag, ".unf"}, ras_underflow, m_unf);
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input string tag, input logic st, br, jp, cl, rt,
                         input logic [5:0] tg, input logic clr);
        stall = st; branch_taken = br; jump = jp; call = cl; ret = rt;
        target = tg; err_clear = clr;
        #1;
        chk({tag, ".pc_next"}, pc_next, model_next(st, br, jp, cl, rt, tg));
        @(posedge clock);
        model_step(st, br, jp, cl, rt, tg, clr);
        #1;
        check_state(tag);
        stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; err_clear = 0;
    endtask

    task automatic idle(input string tag);          cycle(tag, 0, 0, 0, 0, 0, 6'd0, 0); endtask
    task automatic do_jump(input logic [5:0] t);    cycle("jump", 0, 0, 1, 0, 0, t, 0); endtask
    task automatic do_call(input logic [5:0] t);    cycle("call", 0, 0, 0, 1, 0, t, 0); endtask
    task automatic do_ret(input string tag);        cycle(tag, 0, 0, 0, 0, 1, 6'd0, 0); endtask

    initial begin
        reset_n = 1'b0;
        stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; err_clear = 0;
        target = 6'd0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_state("reset");
        reset_n = 1'b1;

        // sequential advance and wrap
        for (int i = 0; i < 10; i++) idle("idle");
        chk("idle10", pc, 10);
        do_jump(6'd63);
        idle("wrap");
        chk("wrap0", pc, 0);

        // branch, and a stalled branch that must be dropped
        do_jump(6'd5);
        cycle("stall_br", 1, 1, 0, 0, 0, 6'd42, 0);
        idle("after_stall");
        do_jump(6'd5);
        cycle("branch", 0, 1, 0, 0, 0, 6'd42, 0);
        chk("branch42", pc, 42);

        // nested call/return
        do_jump(6'd3);
        do_call(6'd20);
        do_call(6'd30);
        do_ret("ret1");
        chk("ret21", pc, 21);
        do_ret("ret2");
        chk("ret4", pc, 4);

        // overflow then underflow
        do_jump(6'd1);
        for (int i = 0; i < 5; i++) do_call(6'd10);
        chk("ovf_set", ras_overflow, 1);
        for (int i = 0; i < 4; i++) do_ret("ret_ovf");
        do_ret("ret_unf");
        chk("unf_pc", pc, 12);

        // call+ret+jump together, then clear (while stalled) and set-wins
        do_jump(6'd8);
        do_call(6'd40);
        cycle("combo", 0, 0, 1, 1, 1, 6'd50, 0);
        chk("combo_pc", pc, 9);
        cycle("clr_stall", 1, 0, 0, 0, 0, 6'd0, 1);
        cycle("set_wins", 0, 0, 0, 0, 1, 6'd0, 1);
        cycle("clr", 0, 0, 0, 0, 0, 6'd0, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), 6'($urandom_range(0, 63)),
                  ($urandom_range(0, 9) == 0));
        end

        // asynchronous reset between edges
        do_call(6'd17);
        do_call(6'd33);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_pc", pc, 0);
        chk("async_count", ras_count, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        do_ret("ret_after_reset");
        chk("post_reset_unf", ras_underflow, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
